pipe_sel_reg: RTL and testbench

Parametrised N:1 select-and-register stage for the 5-stage MIPS pipeline, successor to the combinational 2:1 datapath mux. It picks one of NUM_IN operand channels (forwarding sources, PC candidates, writeback sources) and captures it in a pipeline register. The register supports stall, flush, a valid bit, out-of-range select detection and a saturating bubble counter for performance monitoring. It sits at stage boundaries (ID/EX operand capture, IF PC select) where a mux feeds a pipeline register directly.

---
 rtl/pipe_sel_reg.sv | 98 +++++++++
 tb/tb_pipe_sel_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_sel_reg.sv
// rtl/pipe_sel_reg.sv - N:1 select-and-register pipeline stage with stall, flush, select error and bubble counter
module pipe_sel_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]        Sel,
    input  logic                    InValid,
    input  logic                    Stall,
    input  logic                    Flush,
    input  logic                    CntClr,
    output logic [WIDTH-1:0]        Out,
    output logic                    OutValid,
    output logic                    SelErr,
    output logic [CNT_W-1:0]        BubbleCnt
);

    localparam logic [SEL_W:0] NUM_IN_L = NUM_IN[SEL_W:0];

    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;
    logic             bubble_ev;

    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Unselected codes fall through to zero; out-of-range codes are flagged separately.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (Sel == SEL_W'(k)) begin
                sel_data = In[k*WIDTH +: WIDTH];
            end
        end
        sel_ok = ({1'b0, Sel} < NUM_IN_L);
    end

    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        err_d     = err_q;
        bubble_ev = 1'b0;
        if (Flush) begin
            out_d     = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            bubble_ev = 1'b1;
        end else if (!Stall) begin
            if (sel_ok) begin
                out_d     = sel_data;
                valid_d   = InValid;
                err_d     = 1'b0;
                bubble_ev = !InValid;
            end else begin
                out_d     = '0;
                valid_d   = 1'b0;
                err_d     = 1'b1;
                bubble_ev = 1'b1;
            end
        end
    end

    // Clear wins over a same-cycle bubble; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (CntClr) begin
            cnt_d = '0;
        end else if (bubble_ev && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Out       = out_q;
    assign OutValid  = valid_q;
    assign SelErr    = err_q;
    assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_pipe_sel_reg.sv
// tb/tb_pipe_sel_reg.sv - bench for pipe_sel_reg: NUM_IN=4/CNT_W=8 and NUM_IN=3/CNT_W=4 side by side
module tb_pipe_sel_reg;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] in_v = '0;
    logic [1:0]   sel = '0;
    logic         inv = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         clr = 1'b0;

    logic [31:0]  o0, o1;
    logic         v0, v1, e0, e1;
    logic [7:0]   c0;
    logic [3:0]   c1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_sel_reg #(.WIDTH(32), .NUM_IN(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .In(in_v), .Sel(sel), .InValid(inv),
        .Stall(stall), .Flush(flush), .CntClr(clr),
        .Out(o0), .OutValid(v0), .SelErr(e0), .BubbleCnt(c0)
    );

    pipe_sel_reg #(.WIDTH(32), .NUM_IN(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .In(in_v[95:0]), .Sel(sel), .InValid(inv),
        .Stall(stall), .Flush(flush), .CntClr(clr),
        .Out(o1), .OutValid(v1), .SelErr(e1), .BubbleCnt(c1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference model: per-instance channel count and counter ceiling.
    logic [31:0] m_out[2] = '{32'h0, 32'h0};
    logic        m_val[2] = '{1'b0, 1'b0};
    logic        m_err[2] = '{1'b0, 1'b0};
    int          m_cnt[2] = '{0, 0};
    int          m_nin[2] = '{4, 3};
    int          m_max[2] = '{255, 15};

    always @(posedge clk or negedge rst_n) begin
        bit ev;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_out[i] = '0; m_val[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
            end else begin
                ev = 1'b0;
                if (flush) begin
                    m_out[i] = '0; m_val[i] = 1'b0; m_err[i] = 1'b0; ev = 1'b1;
                end else if (!stall) begin
                    if (int'(sel) < m_nin[i]) begin
                        m_out[i] = in_v[int'(sel)*32 +: 32];
                        m_val[i] = inv;
                        m_err[i] = 1'b0;
                        ev = !inv;
                    end else begin
                        m_out[i] = '0; m_val[i] = 1'b0; m_err[i] = 1'b1; ev = 1'b1;
                    end
                end
                if (clr) m_cnt[i] = 0;
                else if (ev && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("d0.out",   64'(o0), 64'(m_out[0]));
        check("d0.valid", 64'(v0), 64'(m_val[0]));
        check("d0.err",   64'(e0), 64'(m_err[0]));
        check("d0.cnt",   64'(c0), 64'(m_cnt[0]));
        check("d1.out",   64'(o1), 64'(m_out[1]));
        check("d1.valid", 64'(v1), 64'(m_val[1]));
        check("d1.err",   64'(e1), 64'(m_err[1]));
        check("d1.cnt",   64'(c1), 64'(m_cnt[1]));
    end

    function automatic logic [127:0] mk(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic cyc(input logic [127:0] iv, input logic [1:0] s, input logic v,
                       input logic st, input logic fl, input logic cl);
        in_v = iv; sel = s; inv = v; stall = st; flush = fl; clr = cl;
        @(posedge clk);
        #2;
    endtask

    logic [127:0] base;

    initial begin
        base  = mk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        in_v  = base; sel = 2'd2; inv = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset.out0", 64'(o0), 64'h0);
        check("reset.valid0", 64'(v0), 64'h0);
        check("reset.cnt0", 64'(c0), 64'h0);
        rst_n = 1'b1;
        #1;
        check("release.out0", 64'(o0), 64'h0);
        #1;
        cyc(base, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        check("load.out0", 64'(o0), 64'h33333333);
        check("load.valid0", 64'(v0), 64'h1);
        check("load.out1", 64'(o1), 64'h33333333);

        // Stall hold while inputs churn
        cyc(mk(32'hAAAA0000, 32'h1, 32'h2, 32'h3), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stall.pre", 64'(o0), 64'hAAAA0000);
        for (int j = 0; j < 3; j++) begin
            cyc(mk($urandom, $urandom, $urandom, $urandom), 2'(j + 1), 1'(j % 2), 1'b1, 1'b0, 1'b0);
            check("stall.out0", 64'(o0), 64'hAAAA0000);
            check("stall.valid0", 64'(v0), 64'h1);
        end
        check("stall.cnt0", 64'(c0), 64'h0);
        cyc(mk(32'hB0, 32'hB1, 32'hB2, 32'hB3), 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stall.after", 64'(o0), 64'hB1);

        // Flush over stall
        cyc(mk(32'h5, 32'h6, 32'h7, 32'h8), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("flush.pre", 64'(o0), 64'h5);
        cyc(mk(32'h5, 32'h6, 32'h7, 32'h8), 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush.out0", 64'(o0), 64'h0);
        check("flush.valid0", 64'(v0), 64'h0);
        check("flush.cnt0", 64'(c0), 64'h1);
        check("flush.cnt1", 64'(c1), 64'h1);

        // Sel=3 is out of range only for the 3-channel instance
        cyc(base, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("oor.out1", 64'(o1), 64'h0);
        check("oor.valid1", 64'(v1), 64'h0);
        check("oor.err1", 64'(e1), 64'h1);
        check("oor.cnt1", 64'(c1), 64'h2);
        check("oor.out0", 64'(o0), 64'h44444444);
        check("oor.err0", 64'(e0), 64'h0);
        cyc(base, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("oor.clear1", 64'(e1), 64'h0);
        check("oor.next1", 64'(o1), 64'h22222222);

        // Saturation and clear-over-event
        for (int j = 0; j < 20; j++) cyc(base, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat.cnt1", 64'(c1), 64'hF);
        check("sat.cnt0", 64'(c0), 64'd21);
        cyc(base, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr.cnt0", 64'(c0), 64'h0);
        check("clr.cnt1", 64'(c1), 64'h0);

        // Asynchronous reset between edges
        for (int j = 0; j < 7; j++) cyc(base, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(base, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("arst.pre.cnt0", 64'(c0), 64'd7);
        check("arst.pre.valid0", 64'(v0), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("arst.out0", 64'(o0), 64'h0);
        check("arst.valid0", 64'(v0), 64'h0);
        check("arst.cnt0", 64'(c0), 64'h0);
        check("arst.cnt1", 64'(c1), 64'h0);
        @(posedge clk);
        #2;
        check("arst.hold", 64'(v0), 64'h0);
        rst_n = 1'b1;
        cyc(base, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("arst.reload0", 64'(o0), 64'h44444444);
        check("arst.reload_err1", 64'(e1), 64'h1);
        cyc(base, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
